// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter with round-robin tie breaking and a
// BUSY-state wait timeout; each transaction runs IDLE -> BUSY -> DONE.
module mem_port_arbiter #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req0_wr,
    input  logic [15:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic [31:0] req0_rdata,
    output logic        req0_done,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic        req1_wr,
    input  logic [15:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic [31:0] req1_rdata,
    output logic        req1_done,
    output logic        req1_err,
    output logic        mem_valid,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] WaitLimitC = 8'(WAIT_LIMIT);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  waitCnt_q, waitCnt_d;
    logic        timeout_q, timeout_d;
    logic        lastWin_q, lastWin_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        pick1;
    logic [7:0]  waitInc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            wr_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 32'h0;
            waitCnt_q <= 8'd0;
            timeout_q <= 1'b0;
            // lastWin_q = 1 means req1 won last, so the first tie goes to req0
            lastWin_q <= 1'b1;
            rdata0_q  <= 32'h0;
            rdata1_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            waitCnt_q <= waitCnt_d;
            timeout_q <= timeout_d;
            lastWin_q <= lastWin_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        waitCnt_d = waitCnt_q;
        timeout_d = timeout_q;
        lastWin_d = lastWin_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        pick1     = req1_valid && (!req0_valid || !lastWin_q);
        waitInc   = waitCnt_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_d   = BUSY;
                    grant_d   = pick1 ? 2'b10 : 2'b01;
                    wr_d      = pick1 ? req1_wr : req0_wr;
                    addr_d    = pick1 ? req1_addr : req0_addr;
                    wdata_d   = pick1 ? req1_wdata : req0_wdata;
                    waitCnt_d = 8'd0;
                    timeout_d = 1'b0;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_d = DONE;
                    if (!wr_q) begin
                        if (grant_q[1]) rdata1_d = mem_rdata;
                        else            rdata0_d = mem_rdata;
                    end
                end else if (waitInc == WaitLimitC) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    waitCnt_d = waitInc;
                end else begin
                    waitCnt_d = waitInc;
                end
            end
            DONE: begin
                state_d   = IDLE;
                lastWin_d = grant_q[1];
                grant_d   = 2'b00;
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are decoded from registered state only.
    assign mem_valid  = (state_q == BUSY);
    assign mem_wr     = wr_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign grant      = grant_q;
    assign req0_done  = (state_q == DONE) && grant_q[0];
    assign req1_done  = (state_q == DONE) && grant_q[1];
    assign req0_err   = req0_done && timeout_q;
    assign req1_err   = req1_done && timeout_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter, built with WAIT_LIMIT=4
// so the timeout path is short.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_wr, req1_valid, req1_wr;
    logic [15:0] req0_addr, req1_addr;
    logic [31:0] req0_wdata, req1_wdata;
    logic [31:0] req0_rdata, req1_rdata;
    logic        req0_done, req0_err, req1_done, req1_err;
    logic        mem_valid, mem_wr, mem_ready;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [1:0]  grant;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    mem_port_arbiter #(.WAIT_LIMIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_wr    (req0_wr),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_rdata (req0_rdata),
        .req0_done  (req0_done),
        .req0_err   (req0_err),
        .req1_valid (req1_valid),
        .req1_wr    (req1_wr),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_rdata (req1_rdata),
        .req1_done  (req1_done),
        .req1_err   (req1_err),
        .mem_valid  (mem_valid),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .grant      (grant)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] expGrant;
        rst_n = 1'b0;
        req0_valid = 0; req0_wr = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_wr = 0; req1_addr = '0; req1_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
        applyStimulus();
        applyStimulus();
        checkOutput("reset grant", 32'(grant), 32'h0);
        checkOutput("reset mem_valid", 32'(mem_valid), 32'h0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("reset rdata0", req0_rdata, 32'h0);
        checkOutput("reset done0", 32'(req0_done), 32'h0);
        rst_n = 1'b1;

        // Single read from req0 with one wait cycle
        req0_valid = 1; req0_wr = 0; req0_addr = 16'h00AA;
        applyStimulus();
        checkOutput("rd grant", 32'(grant), 32'h1);
        checkOutput("rd mem_valid", 32'(mem_valid), 32'h1);
        checkOutput("rd mem_addr", 32'(mem_addr), 32'h00AA);
        checkOutput("rd mem_wr", 32'(mem_wr), 32'h0);
        req0_valid = 0;
        applyStimulus();
        checkOutput("rd wait mem_valid", 32'(mem_valid), 32'h1);
        checkOutput("rd wait done0", 32'(req0_done), 32'h0);
        mem_ready = 1; mem_rdata = 32'h1;
        applyStimulus();
        checkOutput("rd done0", 32'(req0_done), 32'h1);
        checkOutput("rd err0", 32'(req0_err), 32'h0);
        checkOutput("rd done1", 32'(req1_done), 32'h0);
        checkOutput("rd rdata0", req0_rdata, 32'h1);
        checkOutput("rd done mem_valid", 32'(mem_valid), 32'h0);
        mem_ready = 0;
        applyStimulus();
        checkOutput("rd idle grant", 32'(grant), 32'h0);
        checkOutput("rd idle done0", 32'(req0_done), 32'h0);

        // Stray mem_ready in IDLE
        mem_ready = 1; mem_rdata = 32'hBAD0BAD0;
        applyStimulus();
        checkOutput("stray mem_valid", 32'(mem_valid), 32'h0);
        checkOutput("stray done0", 32'(req0_done), 32'h0);
        checkOutput("stray rdata0", req0_rdata, 32'h1);
        mem_ready = 0;

        // Write from req1, valid dropped during BUSY
        req1_valid = 1; req1_wr = 1; req1_addr = 16'h00AB; req1_wdata = 32'h16;
        applyStimulus();
        checkOutput("wr grant", 32'(grant), 32'h2);
        checkOutput("wr mem_wr", 32'(mem_wr), 32'h1);
        checkOutput("wr mem_addr", 32'(mem_addr), 32'h00AB);
        req1_valid = 0; req1_wdata = 32'hFFFF;
        applyStimulus();
        checkOutput("wr wdata stable", mem_wdata, 32'h16);
        checkOutput("wr mem_valid held", 32'(mem_valid), 32'h1);
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("wr done1", 32'(req1_done), 32'h1);
        checkOutput("wr err1", 32'(req1_err), 32'h0);
        checkOutput("wr done0", 32'(req0_done), 32'h0);
        checkOutput("wr rdata1", req1_rdata, 32'h0);
        mem_ready = 0;
        applyStimulus();

        // Repeated ties alternate 0,1,0,1 back to back
        req0_valid = 1; req1_valid = 1; req0_wr = 0; req1_wr = 0;
        mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            expGrant = (i % 2 == 0) ? 2'b01 : 2'b10;
            mem_rdata = 32'h100 + 32'(i);
            applyStimulus();
            checkOutput($sformatf("tie%0d grant", i), 32'(grant), 32'(expGrant));
            applyStimulus();
            checkOutput($sformatf("tie%0d done", i), 32'({req1_done, req0_done}), 32'(expGrant));
            checkOutput($sformatf("tie%0d rdata", i),
                        expGrant[0] ? req0_rdata : req1_rdata, 32'h100 + 32'(i));
            applyStimulus();
        end
        req0_valid = 0; req1_valid = 0; mem_ready = 0;
        applyStimulus();

        // Timeout on req0 read after 4 BUSY cycles
        req0_valid = 1; req0_addr = 16'h0042;
        applyStimulus();
        req0_valid = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput($sformatf("to busy%0d", i), 32'(mem_valid), 32'h1);
        end
        applyStimulus();
        checkOutput("to done0", 32'(req0_done), 32'h1);
        checkOutput("to err0", 32'(req0_err), 32'h1);
        checkOutput("to mem_valid", 32'(mem_valid), 32'h0);
        checkOutput("to rdata0", req0_rdata, 32'h102);
        applyStimulus();
        checkOutput("to idle err0", 32'(req0_err), 32'h0);

        // Reset mid-BUSY during req1 access
        req1_valid = 1; req1_wr = 1; req1_addr = 16'h1234; req1_wdata = 32'hCAFE;
        applyStimulus();
        checkOutput("rst busy grant", 32'(grant), 32'h2);
        req1_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst mem_valid", 32'(mem_valid), 32'h0);
        checkOutput("rst grant", 32'(grant), 32'h0);
        checkOutput("rst mem_addr", 32'(mem_addr), 32'h0);
        applyStimulus();
        checkOutput("rst no done1", 32'(req1_done), 32'h0);
        rst_n = 1'b1;
        req0_valid = 1; req1_valid = 1; req0_wr = 0; req1_wr = 0;
        applyStimulus();
        checkOutput("post-rst tie grant", 32'(grant), 32'h1);
        req0_valid = 0; req1_valid = 0;
        mem_ready = 1; mem_rdata = 32'h55;
        applyStimulus();
        checkOutput("post-rst done0", 32'(req0_done), 32'h1);
        checkOutput("post-rst done1", 32'(req1_done), 32'h0);
        mem_ready = 0;
        applyStimulus();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: WAIT_LIMIT, 15, maximum BUSY cycles without mem_ready before a timeout; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester N has a pending memory transaction.
REQ-005 req0_wr / req1_wr  input  1  1 = write, 0 = read.
REQ-006 req0_addr / req1_addr  input  16  word address.
REQ-007 req0_wdata / req1_wdata  input  32  write data.
REQ-008 req0_rdata / req1_rdata  output  32  read data returned to requester N.
REQ-009 req0_done / req1_done  output  1  one-cycle completion pulse to requester N.
REQ-010 req0_err / req1_err  output  1  one-cycle timeout flag, coincident with done.
REQ-011 mem_valid  output  1  memory access in progress.
REQ-012 mem_wr, mem_addr[15:0], mem_wdata[31:0]  output  memory command fields.
REQ-013 mem_rdata  input  32  memory read data, valid when mem_ready=1.
REQ-014 mem_ready  input  1  memory has completed the current access.
REQ-015 grant  output  2  one-hot owner of the memory port; 00 when idle.

Function
REQ-016 FSM states: IDLE, BUSY, DONE; encoding is free.
REQ-017 IDLE: no valid -> stay. Any valid at edge -> BUSY; latch the winner's wr, addr and wdata into internal registers; set grant.
REQ-018 Arbitration: single valid wins. Both valid -> winner is the requester not granted last (round-robin pointer). Pointer resets to favour req0.
REQ-019 BUSY: mem_valid=1; mem_wr/mem_addr/mem_wdata driven from latched registers and held stable for the whole state.
REQ-020 BUSY with mem_ready=1 at edge -> DONE. For reads, capture mem_rdata into the winner's rdata register. Writes leave rdata unchanged.
REQ-021 BUSY wait counter: 8-bit, cleared on entry. Increments each BUSY cycle with mem_ready=0. Reaching WAIT_LIMIT -> DONE with error flag set; rdata unchanged.
REQ-022 DONE: exactly one cycle.
  - mem_valid=0.
  - Winner's done=1; err=1 only if timed out.
  - Update pointer to the winner.
  - Next state IDLE; grant clears to 00 on exit.
REQ-023 Requester valid is ignored in BUSY and DONE. Requester shall deassert valid after sampling done; valid still high in IDLE is a new request.
REQ-024 Dropping valid during BUSY does not abort; transaction completes normally.
REQ-025 mem_ready in IDLE or DONE is ignored.
REQ-026 Minimum latency, valid sampled at edge k to done high: edge k enters BUSY; mem_ready=1 in that cycle -> DONE at edge k+1.
REQ-027 Non-winning requester outputs (done, err, rdata) are unaffected by the other requester's transaction.
REQ-028 Outputs done, err, mem_valid and grant are registered or decoded from state only; there is no combinational path from inputs.

Reset
REQ-029 rst_n=0 asynchronously forces:
  - State IDLE.
  - mem_valid=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - grant=00, done=0, err=0, rdata=0.
  - Wait counter 0; pointer favours req0.
REQ-030 Reset mid-BUSY abandons the access with no done or err pulse. First tie after reset release goes to req0.

Verification
REQ-031 Single read: req0 read addr 0x00AA, mem_ready one cycle later, mem_rdata=0x00000001 -> mem_addr=0x00AA, mem_wr=0, req0_rdata=0x1, one req0_done pulse, grant 01 then 00.
REQ-032 Tie: req0 and req1 valid in the same cycle after reset -> req0 served first, req1 served next with no idle cycle beyond DONE/IDLE. Repeated ties alternate 0,1,0,1.
REQ-033 Write: req1 write addr 0x00AB, wdata 0x16 -> mem_wr=1, mem_wdata=0x16 stable until mem_ready. req1_done pulses; req1_rdata unchanged.
REQ-034 Timeout: WAIT_LIMIT=4, mem_ready held 0 -> DONE after 4 BUSY cycles with req0_done=1 and req0_err=1; mem_valid drops.
REQ-035 Reset mid-BUSY: rst_n low during req1 access -> mem_valid=0 immediately, no req1_done. After release, simultaneous requests grant req0.
REQ-036 Stray mem_ready pulses in IDLE and the valid-drop case of REQ-024 -> no state change and no spurious done, respectively.
